// File: rtl/dmem_port_ctrl.sv
// Handshaked data-memory port: byte-lane enables, store-data replication, load extract/extend,
// request FSM with ack timeout. Define MISALIGN_TRAP_EN to make misaligned accesses illegal.
module dmem_port_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     writeData,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [1:0]            maskMode,
   input  logic                  sext,
   output logic [DATA_W-1:0]     readData,
   output logic                  good,
   output logic                  err,
   output logic                  busy,
   output logic                  dmReq,
   output logic                  dmMem_w,
   output logic [ADDR_W-1:0]     dmAddr_out,
   output logic [DATA_W/8-1:0]   dmByteEn,
   output logic [DATA_W-1:0]     dmData_out,
   input  logic [DATA_W-1:0]     dmData_in,
   input  logic                  dmAck
);
   localparam int LANES = DATA_W / 8;
   localparam int OFFW  = $clog2(LANES);
   localparam int CNTW  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYC - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]        state;
   logic [CNTW-1:0]   cnt;
   logic [OFFW-1:0]   offR;
   logic [1:0]        modeR;
   logic              sextR;
   logic              loadR;
   logic [DATA_W-1:0] rawR;

   logic [OFFW-1:0]   off;
   logic [LANES-1:0]  laneEn;
   logic [DATA_W-1:0] repData;
   logic [DATA_W-1:0] ldResult;
   logic              modeLegal;
   logic              misaligned;
   logic              accept;
   logic              illegal;

   assign off  = addr[OFFW-1:0];
   assign busy = (state != IDLE);

   // A lane belongs to the access when it shares the offset bits above the access size.
   always_comb begin
      int unsigned sz;
      int unsigned offU;
      laneEn  = '0;
      repData = '0;
      sz      = 32'(maskMode);
      offU    = 32'(off);
      for (int unsigned i = 0; i < LANES; i++) begin
         laneEn[i]         = ((i ^ offU) >> sz) == 0;
         repData[8*i +: 8] = writeData[8*(i & ((32'd1 << sz) - 32'd1)) +: 8];
      end
   end

   always_comb begin
      modeLegal = (maskMode != 2'b11) || (DATA_W == 64);
`ifdef MISALIGN_TRAP_EN
      misaligned = (32'(off) & ((32'd1 << maskMode) - 32'd1)) != 0;
`else
      misaligned = 1'b0;
`endif
      accept  = valid && (memRead ^ memWrite) && modeLegal && !misaligned;
      illegal = valid && (memRead || memWrite) &&
                ((memRead && memWrite) || !modeLegal || misaligned);
   end

   always_comb begin
      int unsigned sz;
      int unsigned nbits;
      int unsigned base;
      logic [DATA_W-1:0] shifted;
      ldResult = '0;
      sz       = 32'(modeR);
      nbits    = 32'd8 << sz;
      if (nbits > DATA_W) nbits = DATA_W;
      base     = 32'(offR) & ~((32'd1 << sz) - 32'd1);
      shifted  = rawR >> (8 * base);
      for (int unsigned b = 0; b < DATA_W; b++)
         ldResult[b] = (b < nbits) ? shifted[b] : (sextR & shifted[nbits-1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         readData   <= '0;
         good       <= 1'b0;
         err        <= 1'b0;
         dmReq      <= 1'b0;
         dmMem_w    <= 1'b0;
         dmAddr_out <= '0;
         dmByteEn   <= '0;
         dmData_out <= '0;
         offR       <= '0;
         modeR      <= '0;
         sextR      <= 1'b0;
         loadR      <= 1'b0;
         rawR       <= '0;
      end else begin
         good <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= ACCESS;
                  cnt        <= '0;
                  dmReq      <= 1'b1;
                  dmMem_w    <= memWrite;
                  dmAddr_out <= {addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                  dmByteEn   <= laneEn;
                  dmData_out <= repData;
                  offR       <= off;
                  modeR      <= maskMode;
                  sextR      <= sext;
                  loadR      <= memRead;
               end else if (illegal) begin
                  err <= 1'b1;
               end
            end
            ACCESS: begin
               // Ack is checked first so an ack on the final allowed cycle still completes.
               if (dmAck) begin
                  dmReq <= 1'b0;
                  cnt   <= '0;
                  state <= RESP;
                  if (loadR) rawR <= dmData_in;
               end else if (cnt == CNT_LAST) begin
                  dmReq <= 1'b0;
                  cnt   <= '0;
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               good  <= 1'b1;
               state <= IDLE;
               if (loadR) readData <= ldResult;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Scoreboard bench for dmem_port_ctrl: driver pushes expected memory requests and CPU
// responses from an arithmetic model; a monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_dmem_port_ctrl;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int TMO   = 4;
   localparam int LANES = DW / 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             valid = 1'b0;
   logic             memRead = 1'b0;
   logic             memWrite = 1'b0;
   logic             sext = 1'b0;
   logic             dmAck = 1'b0;
   logic [AW-1:0]    addr = '0;
   logic [DW-1:0]    writeData = '0;
   logic [DW-1:0]    dmData_in = '0;
   logic [1:0]       maskMode = '0;
   logic [DW-1:0]    readData;
   logic [DW-1:0]    dmData_out;
   logic             good, err, busy, dmReq, dmMem_w;
   logic [AW-1:0]    dmAddr_out;
   logic [LANES-1:0] dmByteEn;

   dmem_port_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .valid(valid), .addr(addr), .writeData(writeData),
      .memRead(memRead), .memWrite(memWrite), .maskMode(maskMode), .sext(sext),
      .readData(readData), .good(good), .err(err), .busy(busy), .dmReq(dmReq),
      .dmMem_w(dmMem_w), .dmAddr_out(dmAddr_out), .dmByteEn(dmByteEn),
      .dmData_out(dmData_out), .dmData_in(dmData_in), .dmAck(dmAck)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0]    addr;
      logic [LANES-1:0] be;
      logic [DW-1:0]    data;
      logic             memW;
      int               len;
   } req_t;

   typedef struct {
      bit            isErr;
      logic [DW-1:0] rd;
      int            lat;
   } resp_t;

   req_t          reqQ[$];
   resp_t         respQ[$];
   int            delayQ[$];
   logic [DW-1:0] dataQ[$];

   int            checks = 0;
   int            failures = 0;
   int            cycCnt = 0;
   int            issueCyc = 0;
   logic [DW-1:0] lastLoad = '0;
   bit            lateAck = 1'b0;

   always @(posedge clk) cycCnt <= cycCnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flagFail(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Memory: acks after a per-request delay (delays past the timeout never ack in time).
   initial begin : responder
      bit            active = 1'b0;
      int            waitCnt = 0;
      int            curDelay = 0;
      logic [DW-1:0] curData = '0;
      forever begin
         @(negedge clk);
         dmAck     = 1'b0;
         dmData_in = DW'($urandom);
         if (lateAck) begin
            dmAck   = 1'b1;
            lateAck = 1'b0;
         end else if (dmReq === 1'b1) begin
            if (!active) begin
               active  = 1'b1;
               waitCnt = 0;
               if (delayQ.size() != 0) begin
                  curDelay = delayQ.pop_front();
                  curData  = dataQ.pop_front();
               end else begin
                  curDelay = 0;
               end
            end
            if (waitCnt == curDelay) begin
               dmAck     = 1'b1;
               dmData_in = curData;
               active    = 1'b0;
            end else begin
               waitCnt++;
            end
         end else begin
            active = 1'b0;
         end
      end
   end

   initial begin : monitor
      bit    prevReq = 1'b0;
      int    reqLen = 0;
      int    expLen = 0;
      req_t  rq;
      resp_t rs;
      forever begin
         @(negedge clk);
         if (dmReq === 1'b1 && !prevReq) begin
            if (reqQ.size() == 0) flagFail("spurious_dmReq");
            else begin
               rq = reqQ.pop_front();
               check("dmAddr_out", dmAddr_out, rq.addr);
               check("dmByteEn", dmByteEn, rq.be);
               check("dmMem_w", dmMem_w, rq.memW);
               if (rq.memW) check("dmData_out", dmData_out, rq.data);
               expLen = rq.len;
            end
            reqLen = 0;
         end
         if (dmReq === 1'b1) reqLen++;
         if (dmReq !== 1'b1 && prevReq) check("dmReq_len", reqLen, expLen);
         if (good === 1'b1 || err === 1'b1) begin
            if (respQ.size() == 0) flagFail("spurious_good_err");
            else begin
               rs = respQ.pop_front();
               check("resp_err", err, rs.isErr);
               check("resp_good", good, !rs.isErr);
               check("readData", readData, rs.rd);
               check("latency", cycCnt - issueCyc, rs.lat);
               check("busy_at_resp", busy, 1'b0);
            end
         end
         prevReq = (dmReq === 1'b1);
      end
   end

   task automatic doTxn(input bit rd, input bit wr, input logic [1:0] mode, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input bit sx, input int delay,
                        input logic [DW-1:0] md);
      int          size, off, base, budget;
      bit          mis, legalMode;
      logic [63:0] v, mask, rep;
      req_t        rq;
      resp_t       rs;
      size      = 1 << mode;
      off       = int'(a % LANES);
      legalMode = (mode != 2'b11) || (DW == 64);
`ifdef MISALIGN_TRAP_EN
      mis = (off % size) != 0;
`else
      mis = 1'b0;
`endif
      rs.rd = lastLoad;
      if (rd || wr) begin
         if ((rd && wr) || !legalMode || mis) begin
            rs.isErr = 1'b1;
            rs.lat   = 1;
         end else begin
            base = off - off % size;
            if (size * 8 >= 64) mask = '1;
            else mask = (64'd1 << (size * 8)) - 64'd1;
            rep = '0;
            for (int k = 0; k < DW / (8 * size); k++)
               rep = rep | ((64'(wd) & mask) << (k * 8 * size));
            rq.addr = a - AW'(off);
            rq.be   = LANES'(((1 << size) - 1) << base);
            rq.data = DW'(rep);
            rq.memW = wr;
            rq.len  = (delay >= TMO) ? TMO : delay + 1;
            reqQ.push_back(rq);
            delayQ.push_back(delay);
            dataQ.push_back(md);
            if (delay >= TMO) begin
               rs.isErr = 1'b1;
               rs.lat   = 1 + TMO;
            end else begin
               if (rd) begin
                  v = (64'(md) >> (8 * base)) & mask;
                  if (sx && v[size*8-1]) v = v | ~mask;
                  lastLoad = DW'(v);
               end
               rs.isErr = 1'b0;
               rs.rd    = lastLoad;
               rs.lat   = 3 + delay;
            end
         end
         respQ.push_back(rs);
      end
      @(negedge clk);
      valid = 1'b1; memRead = rd; memWrite = wr; maskMode = mode;
      addr = a; writeData = wd; sext = sx; issueCyc = cycCnt;
      @(negedge clk);
      valid = 1'b0; memRead = 1'($urandom); memWrite = 1'($urandom);
      maskMode = 2'($urandom); addr = AW'($urandom); writeData = DW'($urandom); sext = 1'($urandom);
      budget = 0;
      while (respQ.size() != 0 && budget < 40) begin
         @(negedge clk);
         budget++;
      end
      if (respQ.size() != 0) begin
         flagFail("response_timeout");
         respQ.delete();
         reqQ.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      req_t rq;
      repeat (3) @(negedge clk);
      check("rst_readData", readData, '0);
      check("rst_good", good, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_dmReq", dmReq, 1'b0);
      check("rst_dmMem_w", dmMem_w, 1'b0);
      check("rst_dmByteEn", dmByteEn, '0);
      check("rst_dmData_out", dmData_out, '0);
      check("rst_dmAddr_out", dmAddr_out, '0);
      reset = 1'b0;

      doTxn(1, 0, 2'b00, 32'h1003, '0, 1, 0, 32'h80AA5511);
      check("tp_load_byte_sext", readData, 32'hFFFFFF80);
      doTxn(0, 1, 2'b01, 32'h2002, 32'h0000BEEF, 0, 1, '0);
      doTxn(1, 1, 2'b10, 32'h3000, '0, 0, 0, '0);
      doTxn(1, 0, 2'b10, 32'h4000, '0, 0, 9, 32'h12345678);
      doTxn(1, 0, 2'b11, 32'h0018, '0, 0, 0, 32'h00000001);
      doTxn(1, 0, 2'b10, 32'h1002, '0, 0, 0, 32'hCAFEF00D);
      doTxn(0, 0, 2'b10, 32'h5000, '0, 0, 0, '0);
      doTxn(1, 0, 2'b01, 32'h5003, '0, 1, TMO - 1, 32'h9ABC1234);
      doTxn(0, 1, 2'b00, 32'h6001, 32'h000000A5, 0, TMO, '0);

      for (int n = 0; n < 150; n++) begin
         int         r;
         bit         rd, wr;
         logic [1:0] mode;
         r = $urandom_range(0, 99);
         if (r < 8) begin rd = 1'b1; wr = 1'b1; end
         else if (r < 13) begin rd = 1'b0; wr = 1'b0; end
         else begin rd = 1'($urandom); wr = !rd; end
         mode = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         doTxn(rd, wr, mode, AW'($urandom), DW'($urandom), 1'($urandom),
               $urandom_range(0, 5), DW'($urandom));
      end

      rq.addr = 32'h7000; rq.be = '1; rq.data = '0; rq.memW = 1'b0; rq.len = 2;
      reqQ.push_back(rq);
      delayQ.push_back(99);
      dataQ.push_back(32'hDEADBEEF);
      @(negedge clk);
      valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; maskMode = 2'b10; addr = 32'h7000;
      issueCyc = cycCnt;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      lateAck = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_dmReq", dmReq, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_readData", readData, '0);
      lastLoad = '0;
      repeat (6) @(negedge clk);
      doTxn(1, 0, 2'b01, 32'h7002, '0, 0, 2, 32'hF00D0042);

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
